// File: rtl/fpu_arbiter.sv
// fpu_arbiter: two-requester round-robin front end for a single shared FPU,
// with a BUSY-cycle timeout that aborts a hung operation.
// Ports:
//   clk, reset (async, active-low)
//   req_valid[1:0], req_op[9:0], req_a[63:0], req_b[63:0]  per-requester request fields
//   req_ready[1:0]                                         one-hot accept (combinational)
//   resp_valid[1:0], resp_result[31:0], resp_err           one-cycle response to the owner
//   fpu_start, fpu_op[4:0], fpu_a[31:0], fpu_b[31:0]       FPU command, held for the whole op
//   fpu_done, fpu_result[31:0]                             FPU completion
module fpu_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   input  logic [9:0]  req_op,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic [1:0]  req_ready,
   output logic [1:0]  resp_valid,
   output logic [31:0] resp_result,
   output logic        resp_err,
   output logic        fpu_start,
   output logic [4:0]  fpu_op,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   input  logic        fpu_done,
   input  logic [31:0] fpu_result
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t      state;
   logic        rr, owner, err;
   logic [7:0]  cnt;
   logic [4:0]  op;
   logic [31:0] a, b, result;
   logic [1:0]  grant;
   logic        sel;
   always_comb begin
      grant = (req_valid == 2'b11) ? (rr ? 2'b10 : 2'b01) : req_valid;
      // gated by reset so every output reads zero while reset is held
      req_ready = (state == IDLE && reset) ? grant : 2'b00;
   end
   assign sel         = grant[1];
   assign fpu_start   = state == BUSY;
   assign fpu_op      = op;
   assign fpu_a       = a;
   assign fpu_b       = b;
   assign resp_valid  = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign resp_result = result;
   assign resp_err    = err;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         rr     <= 1'b0;
         owner  <= 1'b0;
         err    <= 1'b0;
         cnt    <= '0;
         op     <= '0;
         a      <= '0;
         b      <= '0;
         result <= '0;
      end else begin
         case (state)
            IDLE: if (|req_valid) begin
               owner <= sel;
               op    <= sel ? req_op[9:5]   : req_op[4:0];
               a     <= sel ? req_a[63:32]  : req_a[31:0];
               b     <= sel ? req_b[63:32]  : req_b[31:0];
               cnt   <= '0;
               state <= BUSY;
            end
            BUSY: if (fpu_done) begin
               result <= fpu_result;
               err    <= 1'b0;
               state  <= RESP;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
               result <= 32'h7FC0_0000;
               err    <= 1'b1;
               state  <= RESP;
            end else begin
               cnt <= cnt + 8'd1;
            end
            RESP: begin
               rr    <= ~owner;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: randomized self-checking bench for fpu_arbiter against a
// transaction-timeline reference model (accept cycle + op duration).
module tb_fpu_arbiter;
   localparam int TIMEOUT = 64;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  req_valid = 2'b11;
   logic [9:0]  req_op = '0;
   logic [63:0] req_a = '0;
   logic [63:0] req_b = '0;
   logic [1:0]  req_ready, resp_valid;
   logic [31:0] resp_result, fpu_a, fpu_b;
   logic        resp_err, fpu_start;
   logic [4:0]  fpu_op;
   logic        fpu_done = 1'b1;
   logic [31:0] fpu_result = '0;
   fpu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_result(resp_result), .resp_err(resp_err),
      .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_done(fpu_done), .fpu_result(fpu_result)
   );
   always #5 clk = ~clk;
   int n_chk = 0, n_pass = 0;
   int cyc = 0, t_acc = -10, dur = 0, m_lat = 0, n_acc = 0, n_start = 0;
   bit m_rr = 1'b0, m_owner = 1'b0, m_err = 1'b0;
   logic [4:0]  m_op;
   logic [31:0] m_a, m_b, m_res;
   int force_valid = -1, force_lat = -1;
   bit force_data = 1'b0;
   logic [4:0]  f_op;
   logic [31:0] f_a, f_b, f_res;
   int grants[$];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
   endtask
   function automatic int pick_lat();
      int r;
      r = int'($urandom_range(0, 9));
      return r == 0 ? 1 : r == 1 ? TIMEOUT - 1 : r == 2 ? TIMEOUT : r == 3 ? TIMEOUT + 1 : int'($urandom_range(2, 12));
   endfunction
   // One clock cycle: drive inputs, check outputs against the timeline, advance the model.
   task automatic step();
      bit busy, resp, free;
      logic [1:0] win;
      @(negedge clk);
      busy = cyc > t_acc && cyc <= t_acc + dur;
      resp = cyc == t_acc + dur + 1;
      free = cyc >= t_acc + dur + 2;
      req_valid = force_valid >= 0 ? force_valid[1:0] : 2'($urandom_range(0, 3));
      if (force_data) begin
         req_op = {f_op, f_op};
         req_a  = {f_a, f_a};
         req_b  = {f_b, f_b};
         fpu_result = f_res;
      end else begin
         req_op = 10'($urandom);
         req_a  = {$urandom, $urandom};
         req_b  = {$urandom, $urandom};
         fpu_result = $urandom;
      end
      fpu_done = busy ? (cyc == t_acc + m_lat) : 1'($urandom_range(0, 1));
      if (busy && fpu_done) m_res = fpu_result;
      win = !free ? 2'b00 : (req_valid == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : req_valid;
      #1;
      if (fpu_start) n_start++;
      chk("req_ready", 32'(req_ready), 32'(win));
      chk("fpu_start", 32'(fpu_start), 32'(busy));
      if (busy) begin
         chk("fpu_op", 32'(fpu_op), 32'(m_op));
         chk("fpu_a", fpu_a, m_a);
         chk("fpu_b", fpu_b, m_b);
      end
      chk("resp_valid", 32'(resp_valid), resp ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
      if (resp) begin
         chk("resp_result", resp_result, m_err ? 32'h7FC0_0000 : m_res);
         chk("resp_err", 32'(resp_err), 32'(m_err));
         m_rr = !m_owner;
      end
      if (win != 2'b00) begin
         m_owner = win[1];
         m_op  = m_owner ? req_op[9:5]  : req_op[4:0];
         m_a   = m_owner ? req_a[63:32] : req_a[31:0];
         m_b   = m_owner ? req_b[63:32] : req_b[31:0];
         t_acc = cyc;
         m_lat = force_lat >= 0 ? force_lat : pick_lat();
         dur   = m_lat <= TIMEOUT ? m_lat : TIMEOUT;
         m_err = m_lat > TIMEOUT;
         n_acc++;
         grants.push_back(int'(m_owner));
      end
      cyc++;
   endtask
   task automatic run_txn(input int v, input int lat);
      int start;
      force_valid = v;
      force_lat = lat;
      start = n_acc;
      for (int i = 0; i < 200 && n_acc == start; i++) step();
      chk("accept", 32'(n_acc - start), 32'd1);
      for (int i = 0; i < 200 && cyc < t_acc + dur + 2; i++) step();
   endtask
   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int g0, s0, start;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ctl", {28'd0, req_ready, resp_valid}, 32'd0);
      chk("rst_flags", {30'd0, resp_err, fpu_start}, 32'd0);
      chk("rst_result", resp_result, 32'd0);
      chk("rst_fpu", {27'd0, fpu_op} | fpu_a | fpu_b, 32'd0);
      @(negedge clk);
      req_valid = 2'b00;
      fpu_done = 1'b0;
      reset = 1'b1;
      g0 = grants.size();
      repeat (3) run_txn(3, 1);
      chk("grant0", 32'(grants[g0]), 32'd0);
      chk("grant1", 32'(grants[g0 + 1]), 32'd1);
      chk("grant2", 32'(grants[g0 + 2]), 32'd0);
      force_data = 1'b1;
      f_op = 5'h00; f_a = 32'h3F80_0000; f_b = 32'h4000_0000; f_res = 32'h4040_0000;
      run_txn(1, 1);
      f_op = 5'h03; f_res = 32'h4110_0000;
      s0 = n_start;
      run_txn(1, 20);
      chk("start_len20", 32'(n_start - s0), 32'd20);
      force_data = 1'b0;
      s0 = n_start;
      run_txn(2, TIMEOUT + 1);
      chk("start_len_to", 32'(n_start - s0), 32'(TIMEOUT));
      s0 = n_start;
      run_txn(1, TIMEOUT);
      chk("start_len_lim", 32'(n_start - s0), 32'(TIMEOUT));
      force_valid = -1;
      force_lat = -1;
      repeat (1500) step();
      force_valid = 1;
      force_lat = 1000;
      start = n_acc;
      for (int i = 0; i < 200 && n_acc == start; i++) step();
      chk("accept_pre_rst", 32'(n_acc - start), 32'd1);
      repeat (4) step();
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_ctl", {28'd0, req_ready, resp_valid}, 32'd0);
      chk("midrst_start", 32'(fpu_start), 32'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("midrst_hold", {28'd0, req_ready, resp_valid} | {31'd0, fpu_start}, 32'd0);
      req_valid = 2'b00;
      reset = 1'b1;
      m_rr = 1'b0;
      t_acc = cyc - 10;
      dur = 0;
      run_txn(2, 3);
      chk("post_rst_owner", 32'(grants[grants.size() - 1]), 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, is the maximum number of BUSY cycles allowed before the arbiter aborts an operation; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  request from requester i (bit i).
REQ-005 req_op  input  10  requester i op code at [5i+4:5i].
REQ-006 req_a  input  64  requester i operand A at [32i+31:32i].
REQ-007 req_b  input  64  requester i operand B at [32i+31:32i].
REQ-008 req_ready  output  2  one-hot accept pulse; request i is consumed in the cycle where req_valid[i] and req_ready[i] are both high.
REQ-009 resp_valid  output  2  one-hot, one-cycle response pulse to requester i.
REQ-010 resp_result  output  32  result, meaningful only while resp_valid is non-zero.
REQ-011 resp_err  output  1  timeout flag, meaningful only while resp_valid is non-zero.
REQ-012 fpu_start  output  1  held high for the whole FPU operation.
REQ-013 fpu_op / fpu_a / fpu_b  output  5/32/32  latched op and operands, stable while fpu_start is high.
REQ-014 fpu_done  input  1  FPU completion; may be high in the first start cycle for single-cycle ops.
REQ-015 fpu_result  input  32  FPU result, valid while fpu_done is high.

Function
REQ-016 FSM has three states: IDLE, BUSY, RESP.
REQ-017 IDLE: if any req_valid bit is set, select one requester, pulse its req_ready bit, latch its op, A and B plus an owner bit, clear the timeout counter, and go to BUSY; otherwise stay in IDLE with req_ready=0.
REQ-018 Selection is combinational on the current req_valid. With one valid request, that requester wins; with both valid, the requester named by the round-robin pointer rr wins.
REQ-019 rr is set to the opposite of the owner on each transition from RESP to IDLE.
REQ-020 req_ready is zero in BUSY and RESP; at most one request is in flight.
REQ-021 BUSY: fpu_start=1 and fpu_op/a/b are driven from the latches. If fpu_done=1, latch fpu_result, set err=0 and go to RESP. Otherwise increment the counter.
REQ-022 Timeout: if the counter reaches TIMEOUT-1 with fpu_done=0, set err=1, set the result latch to 32'h7FC00000 (canonical NaN) and go to RESP.
REQ-023 fpu_done and timeout in the same cycle: fpu_done wins and err=0.
REQ-024 RESP: fpu_start=0, resp_valid[owner]=1, resp_result/resp_err come from the latches; go to IDLE unconditionally next cycle.
REQ-025 The fpu_start low cycle in RESP is mandatory; the FPU sequencer relies on it to return to its first state after a completed or aborted op.
REQ-026 fpu_done seen in IDLE or RESP is ignored.
REQ-027 Latency: accept at cycle T, fpu_start from T+1, response at (cycle fpu_done is seen)+1. The minimum is a response at T+2.
REQ-028 Throughput: after a response in cycle R, the next accept can occur in cycle R+1 (IDLE), so the maximum is one op per 3 cycles.
REQ-029 req_op is passed through unmodified; the arbiter does not decode ops.
REQ-030 All outputs except req_ready are registered or decoded from state only. req_ready is combinational from state, req_valid and rr.

Reset
REQ-031 While reset=0: state=IDLE, rr=0, counter=0, owner=0, op/A/B/result latches=0, err=0.
REQ-032 While reset=0, all outputs are 0.
REQ-033 Reset asserted mid-BUSY: fpu_start drops immediately (asynchronously), the in-flight op is discarded and no response is issued.
REQ-034 After reset release, the first arbitration favours requester 0.

Verification
REQ-035 Single request: req_valid=01, op=5'h00, A=3F800000, B=40000000, fpu_done at the first BUSY cycle with result 40400000 -> req_ready=01 at T, fpu_start at T+1, resp_valid=01 with result 40400000 and err=0 at T+2.
REQ-036 Contention: both requests held valid for 3 transactions after reset -> grants in order 0,1,0, with resp_valid matching each grant.
REQ-037 Multi-cycle: op=5'h03, fpu_done 20 cycles after start -> fpu_start high for exactly 20 cycles, operands stable throughout, one response, err=0.
REQ-038 Timeout: TIMEOUT=64, fpu_done never asserted -> fpu_start high for 64 cycles, then resp_err=1 with resp_result=7FC00000 and fpu_start=0 for at least 1 cycle.
REQ-039 Done at the limit: fpu_done asserted in the 64th BUSY cycle -> err=0 and the real result is returned.
REQ-040 Reset mid-op: reset=0 in the 5th BUSY cycle -> fpu_start=0 in the same cycle, no resp_valid; after release a new request on requester 1 is served normally.
